cnt_ser_sequencer: RTL and testbench

CNT_SER_SEQUENCER -- requirements
Module: cnt_ser_sequencer

---
 rtl/psec5_readout_pkg.sv | 22 ++
 rtl/next_chan_sel.sv | 25 ++
 rtl/cnt_ser_sequencer.sv | 150 +++++++++++++++
 tb/tb_cnt_ser_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/psec5_readout_pkg.sv
// Shared constants, state encoding and width helper for the counter serial readout sequencer.
package psec5_readout_pkg;

    localparam int NUM_CH_DEF        = 8;
    localparam int WORDS_PER_CH_DEF  = 5;
    localparam int BITS_PER_WORD_DEF = 10;
    localparam int SEL_W             = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } seq_state_e;

    // Counter width for a terminal count of n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/next_chan_sel.sv
// Finds the lowest enabled channel strictly above ch; none is set when no such channel exists.
// Purely combinational, zero latency, no backpressure.
module next_chan_sel #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 3
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   ch,
    output logic [CH_W-1:0]   nxt,
    output logic              none
);

    always_comb begin
        nxt  = ch;
        none = 1'b1;
        // Descending scan so the lowest qualifying index is the last one written.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(ch))) begin
                nxt  = CH_W'(i);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cnt_ser_sequencer.sv
// Walks the enabled channels and their counter words, driving a one-hot shift enable per burst.
// Latency: one SETUP cycle, a BITS_PER_WORD burst per word with one GAP between bursts, one DONE cycle.
module cnt_ser_sequencer
    import psec5_readout_pkg::*;
#(
    parameter int NUM_CH        = NUM_CH_DEF,
    parameter int WORDS_PER_CH  = WORDS_PER_CH_DEF,
    parameter int BITS_PER_WORD = BITS_PER_WORD_DEF
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              inst_readout,
    input  logic              abort,
    input  logic [NUM_CH-1:0] chan_mask,
    output logic [NUM_CH-1:0] load_cnt_ser,
    output logic [SEL_W-1:0]  select_reg,
    output logic              busy,
    output logic              done
);

    localparam int CH_W   = cnt_width(NUM_CH);
    localparam int WORD_W = cnt_width(WORDS_PER_CH);
    localparam int BIT_W  = cnt_width(BITS_PER_WORD);

    seq_state_e        state, state_nxt;
    logic [NUM_CH-1:0] mask_q, mask_nxt;
    logic [CH_W-1:0]   ch, ch_nxt, ch_above, first_ch;
    logic              none_above;
    logic [WORD_W-1:0] word_cnt, word_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [NUM_CH-1:0] load_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic              busy_nxt, done_nxt;

    next_chan_sel #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_next_chan_sel (
        .mask (mask_q),
        .ch   (ch),
        .nxt  (ch_above),
        .none (none_above)
    );

    always_comb begin
        first_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (chan_mask[i]) first_ch = CH_W'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        mask_nxt  = mask_q;
        ch_nxt    = ch;
        word_nxt  = word_cnt;
        bit_nxt   = bit_cnt;
        load_nxt  = '0;
        sel_nxt   = select_reg;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                busy_nxt = 1'b0;
                if (inst_readout) begin
                    busy_nxt = 1'b1;
                    if (|chan_mask) begin
                        state_nxt = ST_SETUP;
                        mask_nxt  = chan_mask;
                        ch_nxt    = first_ch;
                        word_nxt  = '0;
                        bit_nxt   = '0;
                        sel_nxt   = '0;
                    end else begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_SETUP, ST_GAP: begin
                state_nxt    = ST_SHIFT;
                bit_nxt      = '0;
                load_nxt[ch] = 1'b1;
            end
            ST_SHIFT: begin
                if (bit_cnt == BIT_W'(BITS_PER_WORD - 1)) begin
                    bit_nxt = '0;
                    // The next select value goes out during GAP so the channel mux settles before the burst.
                    if (word_cnt != WORD_W'(WORDS_PER_CH - 1)) begin
                        state_nxt = ST_GAP;
                        word_nxt  = word_cnt + 1'b1;
                        sel_nxt   = SEL_W'(word_cnt + 1'b1);
                    end else if (!none_above) begin
                        state_nxt = ST_GAP;
                        word_nxt  = '0;
                        sel_nxt   = '0;
                        ch_nxt    = ch_above;
                    end else begin
                        state_nxt = ST_DONE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    bit_nxt      = bit_cnt + 1'b1;
                    load_nxt[ch] = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        if (abort && (state != ST_IDLE)) begin
            state_nxt = ST_IDLE;
            load_nxt  = '0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_IDLE;
            mask_q       <= '0;
            ch           <= '0;
            word_cnt     <= '0;
            bit_cnt      <= '0;
            load_cnt_ser <= '0;
            select_reg   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            mask_q       <= mask_nxt;
            ch           <= ch_nxt;
            word_cnt     <= word_nxt;
            bit_cnt      <= bit_nxt;
            load_cnt_ser <= load_nxt;
            select_reg   <= sel_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

endmodule

// File: tb/tb_cnt_ser_sequencer.sv
// Directed bench for cnt_ser_sequencer with behavioural channel shift registers and output mux.
module tb_cnt_ser_sequencer;

    logic       sclk = 1'b0;
    logic       rstn;
    logic       inst_readout;
    logic       abort;
    logic [7:0] chan_mask;
    logic [7:0] load_cnt_ser;
    logic [2:0] select_reg;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [9:0] chw [8][5];

    typedef struct {
        logic [7:0] mask;
        int         exp_load;
        int         exp_gap;
        int         exp_total;
    } vec_t;

    vec_t vecs [6];

    cnt_ser_sequencer dut (
        .sclk         (sclk),
        .rstn         (rstn),
        .inst_readout (inst_readout),
        .abort        (abort),
        .chan_mask    (chan_mask),
        .load_cnt_ser (load_cnt_ser),
        .select_reg   (select_reg),
        .busy         (busy),
        .done         (done)
    );

    always #5 sclk = ~sclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [7:0] v);
        int r = -1;
        for (int i = 0; i < 8; i++) if (v[i]) r = i;
        return r;
    endfunction

    // One readout from request to the cycle after done, reconstructing every word through the mux model.
    task automatic run_case(input logic [7:0] m, input int exp_load, input int exp_gap, input int exp_total);
        int         en[$];
        int         total = 0, load_cnt = 0, gap = 0, dcnt = 0, ohe = 0, seqe = 0, bursts = 0;
        int         k = 0, bch = 0, idx;
        logic [2:0] bsel = '0;
        logic [9:0] cap = '0, w;
        logic [7:0] prev = '0;
        bit         fin = 1'b0;
        string      tag;

        tag = $sformatf("mask %02h", m);
        for (int i = 0; i < 8; i++) if (m[i]) en.push_back(i);
        @(negedge sclk);
        chan_mask    = m;
        inst_readout = 1'b1;
        @(negedge sclk);
        inst_readout = 1'b0;
        chan_mask    = ~m;
        for (int cyc = 0; cyc < exp_total + 20 && !fin; cyc++) begin
            if (busy) total++;
            if (done) begin
                dcnt++;
                fin = 1'b1;
            end
            if ($countones(load_cnt_ser) > 1) ohe++;
            idx = oh_idx(load_cnt_ser);
            if (load_cnt_ser != 8'h00) begin
                load_cnt++;
                if (prev == 8'h00) begin
                    bch  = idx;
                    bsel = select_reg;
                    k    = 0;
                    cap  = '0;
                end else if (load_cnt_ser != prev || select_reg != bsel) begin
                    seqe++;
                end
                if (k < 10 && select_reg < 3'd5) begin
                    w   = chw[idx][select_reg];
                    cap = {cap[8:0], w[9-k]};
                end
                k++;
            end else if (prev != 8'h00) begin
                if (busy && !done) gap++;
                if (k != 10 || bursts >= en.size() * 5 || bch != en[bursts/5] ||
                    int'(bsel) != bursts % 5 || cap != chw[bch][bsel])
                    seqe++;
                bursts++;
            end
            prev = load_cnt_ser;
            if (cyc == 20) inst_readout = 1'b1;
            if (cyc == 21) inst_readout = 1'b0;
            @(negedge sclk);
        end
        inst_readout = 1'b0;
        check({tag, " done pulses"}, dcnt, 1);
        check({tag, " busy cycles"}, total, exp_total);
        check({tag, " load-high cycles"}, load_cnt, exp_load);
        check({tag, " gap cycles"}, gap, exp_gap);
        check({tag, " bursts"}, bursts, en.size() * 5);
        check({tag, " burst order/data errors"}, seqe, 0);
        check({tag, " one-hot violations"}, ohe, 0);
        check({tag, " idle after done"}, {busy, done, load_cnt_ser}, 0);
    endtask

    initial begin
        int  found;
        int  bad;

        for (int c = 0; c < 8; c++)
            for (int w = 0; w < 5; w++)
                chw[c][w] = 10'(c * 113 + w * 29 + 7) ^ 10'h155;

        vecs[0] = '{8'h01,  50,  4,  56};
        vecs[1] = '{8'hA5, 200, 19, 221};
        vecs[2] = '{8'h00,   0,  0,   1};
        vecs[3] = '{8'h80,  50,  4,  56};
        vecs[4] = '{8'h24, 100,  9, 111};
        vecs[5] = '{8'hFF, 400, 39, 441};

        rstn         = 1'b0;
        inst_readout = 1'b0;
        abort        = 1'b0;
        chan_mask    = 8'h00;
        @(negedge sclk);
        @(negedge sclk);
        check("reset state", {load_cnt_ser, select_reg, busy, done}, 0);
        rstn = 1'b1;
        @(negedge sclk);

        for (int v = 0; v < 6; v++)
            run_case(vecs[v].mask, vecs[v].exp_load, vecs[v].exp_gap, vecs[v].exp_total);

        // Abort on the third bit of channel 2, word 1.
        @(negedge sclk);
        chan_mask    = 8'h05;
        inst_readout = 1'b1;
        @(negedge sclk);
        inst_readout = 1'b0;
        found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            if (load_cnt_ser == 8'h04 && select_reg == 3'd1) found = 1;
            else @(negedge sclk);
        end
        check("abort target reached", found, 1);
        @(negedge sclk);
        @(negedge sclk);
        check("abort still shifting", {load_cnt_ser, select_reg}, {8'h04, 3'd1});
        abort = 1'b1;
        @(negedge sclk);
        abort = 1'b0;
        check("abort clears outputs", {load_cnt_ser, busy, done}, 0);
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            if (done || busy || load_cnt_ser != 8'h00) bad++;
            @(negedge sclk);
        end
        check("abort stays idle without done", bad, 0);

        // Abort alone in IDLE does nothing; abort together with a request loses to the request.
        abort = 1'b1;
        bad   = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge sclk);
            if (busy || done) bad++;
        end
        check("abort in idle ignored", bad, 0);
        chan_mask    = 8'h01;
        inst_readout = 1'b1;
        @(negedge sclk);
        abort        = 1'b0;
        inst_readout = 1'b0;
        check("request beats abort in idle", busy, 1);
        found = 0;
        for (int c = 0; c < 80 && found == 0; c++) begin
            @(negedge sclk);
            if (done) found = c + 2;
        end
        check("request beats abort completes", found, 56);

        // Level-sensitive request with an empty mask: done, idle, done.
        @(negedge sclk);
        chan_mask    = 8'h00;
        inst_readout = 1'b1;
        @(negedge sclk);
        check("level req first done", {busy, done, load_cnt_ser}, {2'b11, 8'h00});
        @(negedge sclk);
        check("level req idle gap", {busy, done}, 0);
        @(negedge sclk);
        inst_readout = 1'b0;
        check("level req second done", {busy, done}, 2'b11);
        @(negedge sclk);

        // Asynchronous reset in the middle of a burst.
        chan_mask    = 8'h02;
        inst_readout = 1'b1;
        @(negedge sclk);
        inst_readout = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (load_cnt_ser == 8'h02 && select_reg == 3'd2) found = 1;
            else @(negedge sclk);
        end
        check("reset target reached", found, 1);
        @(negedge sclk);
        @(negedge sclk);
        #2;
        rstn = 1'b0;
        #1;
        check("async reset clears outputs", {load_cnt_ser, select_reg, busy, done}, 0);
        @(negedge sclk);
        rstn = 1'b1;
        bad  = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge sclk);
            if (busy || done || load_cnt_ser != 8'h00) bad++;
        end
        check("idle after reset release", bad, 0);
        run_case(8'h01, 50, 4, 56);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
